// File: rtl/status_register_unit.sv
// NZCV status register with a same-cycle EXE-to-ID bypass.
// It also holds a one-entry shadow copy for exception save/restore
// and a wrapping counter of flag commits for debug visibility.
// Flag bit order everywhere is {Z,C,N,V}: [3]=Z, [2]=C, [1]=N, [0]=V.
module status_register_unit #(
   parameter int         CNT_W       = 16,
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             exe_valid,
   input  logic             exe_flush,
   input  logic             freeze,
   input  logic             exe_s,
   input  logic             exe_logic,
   input  logic [3:0]       alu_flags,
   input  logic             shifter_carry,
   input  logic             save,
   input  logic             restore,
   output logic [3:0]       status_register,
   output logic [3:0]       status_fwd,
   output logic [CNT_W-1:0] commit_count
);

   logic [3:0]       sr_q;
   logic [3:0]       sr_d;
   logic [3:0]       shadow_q;
   logic [3:0]       shadow_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             commit;
   logic [3:0]       new_flags;
   logic [3:0]       fwd;

   // A restore owns the cycle, so it also blocks the commit of the
   // instruction in EXE; a stalled instruction commits once it is released.
   assign commit = exe_valid & exe_s & ~exe_flush & ~freeze & ~restore;

   // Logical/move ops take C from the shifter and leave V untouched.
   always_comb begin
      new_flags = alu_flags;
      if (exe_logic) begin
         new_flags = {alu_flags[3], shifter_carry, alu_flags[1], sr_q[0]};
      end
   end

   // Bypass value: what the register will hold after this edge.
   always_comb begin
      fwd = sr_q;
      if (restore) begin
         fwd = shadow_q;
      end else if (commit) begin
         fwd = new_flags;
      end
   end

   // Next-state selection for the status register, shadow and counter.
   always_comb begin
      sr_d     = sr_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      if (restore) begin
         sr_d = shadow_q;
      end else if (commit) begin
         sr_d  = new_flags;
         cnt_d = cnt_q + 1'b1;
      end
      // Saving the bypassed value captures a commit in the same cycle.
      if (save && !restore) begin
         shadow_d = fwd;
      end
   end

   // State registers; reset takes effect immediately and overrides all.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q     <= RESET_FLAGS;
         shadow_q <= 4'b0000;
         cnt_q    <= '0;
      end else begin
         sr_q     <= sr_d;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
      end
   end

   assign status_register = sr_q;
   assign status_fwd      = fwd;
   assign commit_count    = cnt_q;

endmodule

// File: tb/tb_status_register_unit.sv
// Self-checking bench for status_register_unit: a vector table drives the
// core flag behaviour, a queue carries post-edge expectations, and short
// hand-written sequences cover the asynchronous reset corner.
module tb_status_register_unit;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             exe_valid = 1'b0;
   logic             exe_flush = 1'b0;
   logic             freeze = 1'b0;
   logic             exe_s = 1'b0;
   logic             exe_logic = 1'b0;
   logic [3:0]       alu_flags = 4'b0000;
   logic             shifter_carry = 1'b0;
   logic             save = 1'b0;
   logic             restore = 1'b0;
   logic [3:0]       status_register;
   logic [3:0]       status_fwd;
   logic [CNT_W-1:0] commit_count;

   int checks = 0;
   int errors = 0;

   status_register_unit #(.CNT_W(CNT_W), .RESET_FLAGS(4'b0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .exe_valid       (exe_valid),
      .exe_flush       (exe_flush),
      .freeze          (freeze),
      .exe_s           (exe_s),
      .exe_logic       (exe_logic),
      .alu_flags       (alu_flags),
      .shifter_carry   (shifter_carry),
      .save            (save),
      .restore         (restore),
      .status_register (status_register),
      .status_fwd      (status_fwd),
      .commit_count    (commit_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v, f, fr, s, l;
      logic [3:0] alu;
      logic       sc, sv, rs;
      logic [3:0] exp_fwd;
      logic [3:0] exp_sr;
      int         exp_cnt;
   } vec_t;

   typedef struct {
      int         idx;
      logic [3:0] sr;
      int         cnt;
   } exp_t;

   vec_t tbl[27];
   exp_t sb[$];

   function automatic vec_t mk(logic v, logic f, logic fr, logic s, logic l,
                               logic [3:0] alu, logic sc, logic sv, logic rs,
                               logic [3:0] ef, logic [3:0] esr, int ec);
      vec_t r;
      r.v = v; r.f = f; r.fr = fr; r.s = s; r.l = l;
      r.alu = alu; r.sc = sc; r.sv = sv; r.rs = rs;
      r.exp_fwd = ef; r.exp_sr = esr; r.exp_cnt = ec;
      return r;
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic v, logic f, logic fr, logic s, logic l,
                        logic [3:0] alu, logic sc, logic sv, logic rs);
      exe_valid = v; exe_flush = f; freeze = fr; exe_s = s; exe_logic = l;
      alu_flags = alu; shifter_carry = sc; save = sv; restore = rs;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      //           v  f  fr s  l  alu      sc sv rs  fwd      sr       cnt
      tbl[0]  = mk(1, 0, 0, 1, 0, 4'b1010, 0, 0, 0, 4'b1010, 4'b1010, 1);
      tbl[1]  = mk(0, 0, 0, 1, 0, 4'b1111, 0, 0, 0, 4'b1010, 4'b1010, 1);
      tbl[2]  = mk(1, 0, 0, 1, 0, 4'b0001, 0, 0, 0, 4'b0001, 4'b0001, 2);
      tbl[3]  = mk(1, 0, 0, 1, 1, 4'b1010, 1, 0, 0, 4'b1111, 4'b1111, 3);
      tbl[4]  = mk(1, 0, 0, 1, 0, 4'b0001, 0, 0, 0, 4'b0001, 4'b0001, 4);
      tbl[5]  = mk(1, 0, 0, 1, 1, 4'b1000, 1, 0, 0, 4'b1101, 4'b1101, 5);
      tbl[6]  = mk(1, 1, 0, 1, 0, 4'b1111, 0, 0, 0, 4'b1101, 4'b1101, 5);
      tbl[7]  = mk(1, 0, 0, 0, 0, 4'b1111, 0, 0, 0, 4'b1101, 4'b1101, 5);
      tbl[8]  = mk(1, 0, 0, 1, 1, 4'b0110, 0, 0, 0, 4'b0011, 4'b0011, 6);
      tbl[9]  = mk(1, 0, 0, 1, 1, 4'b1111, 0, 0, 0, 4'b1011, 4'b1011, 7);
      tbl[10] = mk(1, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 8);
      tbl[11] = mk(1, 0, 1, 1, 0, 4'b0110, 0, 0, 0, 4'b0000, 4'b0000, 8);
      tbl[12] = mk(1, 0, 1, 1, 0, 4'b0110, 0, 0, 0, 4'b0000, 4'b0000, 8);
      tbl[13] = mk(1, 0, 1, 1, 0, 4'b0110, 0, 0, 0, 4'b0000, 4'b0000, 8);
      tbl[14] = mk(1, 0, 0, 1, 0, 4'b0110, 0, 0, 0, 4'b0110, 4'b0110, 9);
      tbl[15] = mk(0, 0, 0, 1, 0, 4'b0110, 0, 0, 0, 4'b0110, 4'b0110, 9);
      tbl[16] = mk(1, 0, 0, 1, 0, 4'b0100, 0, 0, 0, 4'b0100, 4'b0100, 10);
      tbl[17] = mk(1, 0, 0, 1, 0, 4'b1001, 0, 1, 0, 4'b1001, 4'b1001, 11);
      tbl[18] = mk(1, 0, 0, 1, 0, 4'b0010, 0, 0, 0, 4'b0010, 4'b0010, 12);
      tbl[19] = mk(1, 0, 0, 1, 0, 4'b1111, 0, 0, 1, 4'b1001, 4'b1001, 12);
      tbl[20] = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b1001, 4'b1001, 12);
      tbl[21] = mk(1, 0, 0, 1, 0, 4'b0110, 0, 1, 0, 4'b0110, 4'b0110, 13);
      tbl[22] = mk(1, 0, 0, 1, 0, 4'b0011, 0, 0, 0, 4'b0011, 4'b0011, 14);
      tbl[23] = mk(1, 0, 0, 1, 0, 4'b1111, 0, 1, 1, 4'b0110, 4'b0110, 14);
      tbl[24] = mk(1, 0, 0, 1, 0, 4'b1100, 0, 0, 0, 4'b1100, 4'b1100, 15);
      tbl[25] = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 4'b0110, 4'b0110, 15);
      tbl[26] = mk(0, 0, 0, 1, 1, 4'b1111, 1, 1, 0, 4'b0110, 4'b0110, 15);

      // Outputs while held in reset.
      #2;
      check("rst_sr", status_register, 4'b0000);
      check("rst_fwd", status_fwd, 4'b0000);
      check("rst_cnt", commit_count, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_sr", status_register, 4'b0000);
      check("idle_fwd", status_fwd, 4'b0000);
      check("idle_cnt", commit_count, 0);

      // Table: fwd checked in the drive cycle, sr/count after the edge.
      for (int i = 0; i < 27; i++) begin
         drive(tbl[i].v, tbl[i].f, tbl[i].fr, tbl[i].s, tbl[i].l,
               tbl[i].alu, tbl[i].sc, tbl[i].sv, tbl[i].rs);
         #1;
         check($sformatf("vec%0d_fwd", i), status_fwd, tbl[i].exp_fwd);
         sb.push_back('{i, tbl[i].exp_sr, tbl[i].exp_cnt});
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got 0 entries, expected 1");
         end else begin
            e = sb.pop_front();
            check($sformatf("vec%0d_sr", e.idx), status_register, e.sr);
            check($sformatf("vec%0d_cnt", e.idx), commit_count, e.cnt);
         end
         $display("vec %0d: fwd=%b sr=%b cnt=%0d", i, status_fwd, status_register, commit_count);
         @(negedge clk);
      end

      // Asynchronous reset mid-cycle overrides a pending commit/save/restore.
      drive(1, 0, 0, 1, 0, 4'b1111, 0, 1, 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_sr", status_register, 4'b0000);
      check("arst_cnt", commit_count, 0);
      check("arst_fwd", status_fwd, 4'b0000);
      $display("async reset: sr=%b fwd=%b cnt=%0d", status_register, status_fwd, commit_count);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
      rst = 1'b0;
      // Commit 1111, then restore: shadow must have been cleared by reset.
      drive(1, 0, 0, 1, 0, 4'b1111, 0, 0, 0);
      @(posedge clk);
      #1;
      check("post_rst_commit_sr", status_register, 4'b1111);
      check("post_rst_commit_cnt", commit_count, 1);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 4'b0000, 0, 0, 1);
      #1;
      check("post_rst_restore_fwd", status_fwd, 4'b0000);
      @(posedge clk);
      #1;
      check("post_rst_restore_sr", status_register, 4'b0000);
      check("post_rst_restore_cnt", commit_count, 1);
      $display("post reset restore: sr=%b cnt=%0d", status_register, commit_count);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
